// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode/result bundle between decode logic and the alu
//
// Signals:
//   A, B     [3:0]  unsigned operands, driven by master
//   ctrl     [2:0]  opcode select, driven by master
//   enable          capture enable, driven by master
//   result   [3:0]  registered result, driven by slave (alu)
//   zero            registered result-is-zero flag, driven by slave
//   overflow        registered carry/borrow flag, driven by slave
// Modports: master (decode side), slave (alu side).

interface alu_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] ctrl;
    logic       enable;
    logic [3:0] result;
    logic       zero;
    logic       overflow;

    modport master (
        output A, B, ctrl, enable,
        input  result, zero, overflow
    );

    modport slave (
        input  A, B, ctrl, enable,
        output result, zero, overflow
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 4-bit registered ALU with zero and carry/borrow flags
//
// Ports:
//   clk   input   rising-edge clock
//   rst   input   asynchronous active-high reset
//   bus   alu_if.slave
//         A/B/ctrl/enable in; result/zero/overflow out, all registered
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A,
//          110 LT (unsigned), 111 GT (unsigned).

module alu (
    input  logic        clk,
    input  logic        rst,
    alu_if.slave        bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LT  = 3'b110,
        OP_GT  = 3'b111
    } op_t;

    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic [3:0] w_result;
    logic       w_overflow;

    logic [3:0] r_result;
    logic       r_zero;
    logic       r_overflow;

    // 5-bit extended arithmetic: bit 4 of the sum is the carry-out, bit 4 of
    // the difference is set exactly when A < B (borrow).
    assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff = {1'b0, bus.A} - {1'b0, bus.B};

    always_comb begin
        w_result   = 4'b0000;
        w_overflow = 1'b0;
        case (op_t'(bus.ctrl))
            OP_ADD: begin
                w_result   = w_sum[3:0];
                w_overflow = w_sum[4];
            end
            OP_SUB: begin
                w_result   = w_diff[3:0];
                w_overflow = w_diff[4];
            end
            OP_AND: w_result = bus.A & bus.B;
            OP_OR:  w_result = bus.A | bus.B;
            OP_XOR: w_result = bus.A ^ bus.B;
            OP_NOT: w_result = ~bus.A;
            OP_LT:  w_result = {3'b000, (bus.A < bus.B)};
            OP_GT:  w_result = {3'b000, (bus.A > bus.B)};
            default: begin
                w_result   = 4'b0000;
                w_overflow = 1'b0;
            end
        endcase
    end

    // zero is derived from the value being registered so it can never lag
    // the result by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= 4'b0000;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
        end else if (bus.enable) begin
            r_result   <= w_result;
            r_zero     <= (w_result == 4'b0000);
            r_overflow <= w_overflow;
        end
    end

    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: vector table, corner sequences, random vs model

module tb_alu;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       z;
        logic       ov;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [3:0] res, input logic z,
                         input logic ov);
        total++;
        if (bus.result !== res || bus.zero !== z || bus.overflow !== ov) begin
            bad++;
            $display("FAIL %s: got result=%b zero=%b overflow=%b, want result=%b zero=%b overflow=%b",
                     name, bus.result, bus.zero, bus.overflow, res, z, ov);
        end
    endtask

    // Reference: plain integer arithmetic from the opcode definitions.
    function automatic logic [5:0] model(input int a, input int b, input int op);
        int r;
        int ov;
        r  = 0;
        ov = 0;
        case (op)
            0: begin r = (a + b) % 16;      ov = (a + b > 15) ? 1 : 0; end
            1: begin r = (a - b + 16) % 16; ov = (a < b) ? 1 : 0;      end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: r = (a < b) ? 1 : 0;
            7: r = (a > b) ? 1 : 0;
            default: r = 0;
        endcase
        return {r[3:0], (r == 0), ov[0]};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic en);
        bus.A      = a;
        bus.B      = b;
        bus.ctrl   = op;
        bus.enable = en;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  wide;
        logic [3:0]  exp_res;
        logic        exp_z;
        logic        exp_ov;
        logic [5:0]  m;

        total = 0;
        bad   = 0;

        vecs[0]  = '{4'b0011, 4'b0010, 3'b000, 4'b0101, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0010, 3'b001, 4'b0010, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0001, 3'b001, 4'b1111, 1'b0, 1'b1};
        vecs[4]  = '{4'b1111, 4'b0000, 3'b001, 4'b1111, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 3'b001, 4'b0000, 1'b1, 1'b0};
        vecs[6]  = '{4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{4'b1100, 4'b1010, 3'b011, 4'b1110, 1'b0, 1'b0};
        vecs[8]  = '{4'b1100, 4'b1010, 3'b100, 4'b0110, 1'b0, 1'b0};
        vecs[9]  = '{4'b1100, 4'b1010, 3'b101, 4'b0011, 1'b0, 1'b0};
        vecs[10] = '{4'b0101, 4'b1001, 3'b110, 4'b0001, 1'b0, 1'b0};
        vecs[11] = '{4'b1001, 4'b0101, 3'b111, 4'b0001, 1'b0, 1'b0};
        vecs[12] = '{4'b1000, 4'b1000, 3'b110, 4'b0000, 1'b1, 1'b0};
        vecs[13] = '{4'b1000, 4'b1000, 3'b111, 4'b0000, 1'b1, 1'b0};
        vecs[14] = '{4'b1111, 4'b1110, 3'b110, 4'b0000, 1'b1, 1'b0};
        vecs[15] = '{4'b1000, 4'b0111, 3'b000, 4'b1111, 1'b0, 1'b0};
        vecs[16] = '{4'b1001, 4'b0111, 3'b000, 4'b0000, 1'b1, 1'b1};
        vecs[17] = '{4'b0111, 4'b1000, 3'b111, 4'b0000, 1'b1, 1'b0};

        // Reset asserted with no clock edge must clear outputs at once.
        rst = 1'b0;
        drive(4'b0011, 4'b0010, 3'b000, 1'b1);
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        check("reset_held", 4'b0000, 1'b1, 1'b0);
        rst = 1'b0;
        drive(4'b0011, 4'b0010, 3'b000, 1'b0);
        step();
        step();
        check("hold_after_reset", 4'b0000, 1'b1, 1'b0);

        // Directed vector table, one edge each.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            step();
            check($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].ov);
        end

        // Opcode wider than the port is truncated: 4'b1001 behaves as SUB.
        @(negedge clk);
        wide = 4'b1001;
        drive(4'b0010, 4'b0101, wide[2:0], 1'b1);
        step();
        check("trunc_sub", 4'b1101, 1'b0, 1'b1);

        // Enable low holds through three edges of changing inputs.
        @(negedge clk);
        drive(4'b0110, 4'b0011, 3'b000, 1'b1);
        step();
        check("hold_setup", 4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'(i * 5 + 1), 4'(15 - i), 3'(i + 1), 1'b0);
            step();
            check($sformatf("hold_edge%0d", i), 4'b1001, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(4'b1111, 4'b0011, 3'b000, 1'b1);
        #1;
        check("pre_enable_edge", 4'b1001, 1'b0, 1'b0);
        step();
        check("enable_latency", 4'b0010, 1'b0, 1'b1);

        // Reset pulse between edges with enable high and nonzero inputs.
        @(negedge clk);
        drive(4'b0101, 4'b0110, 3'b011, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_reset_clear", 4'b0000, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_reset_released", 4'b0000, 1'b1, 1'b0);
        step();
        check("mid_reset_next_edge", 4'b0111, 1'b0, 1'b0);

        // Random stimulus against the reference model, tracking hold state.
        exp_res = 4'b0111;
        exp_z   = 1'b0;
        exp_ov  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            int op;
            logic en;
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 7));
            en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            drive(4'(a), 4'(b), 3'(op), en);
            step();
            if (en) begin
                m       = model(a, b, op);
                exp_res = m[5:2];
                exp_z   = m[1];
                exp_ov  = m[0];
            end
            check($sformatf("rand%0d", i), exp_res, exp_z, exp_ov);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
